// File: rtl/m68k_bus_master.sv
// m68k_bus_master
// Synchronous 68000-style bus initiator. Converts single-word client
// requests into nAS/nUDS/nLDS/RW bus cycles, finishes each cycle on nDTACK
// and aborts with ERR after TIMEOUT unacknowledged S4 cycles.
//
// Ports:
//   CLK_68KCLK, RESET             clock, synchronous active-high reset
//   REQ, REQ_WE, REQ_ADDR,
//   REQ_BE, REQ_WDATA             client request (sampled in IDLE only)
//   BUSY, ACK, ERR, RDATA, WAITS  client status / completion
//   M68K_ADDR, M68K_DOUT,
//   M68K_DOUT_EN, M68K_DIN        bus address and data
//   nAS, nUDS, nLDS, M68K_RW      bus strobes
//   nDTACK                        acknowledge from wait-state logic
module m68k_bus_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK_68KCLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        REQ_WE,
  input  logic [22:0] REQ_ADDR,
  input  logic [1:0]  REQ_BE,
  input  logic [15:0] REQ_WDATA,
  output logic        BUSY,
  output logic        ACK,
  output logic        ERR,
  output logic [15:0] RDATA,
  output logic [7:0]  WAITS,
  output logic [22:0] M68K_ADDR,
  output logic [15:0] M68K_DOUT,
  output logic        M68K_DOUT_EN,
  input  logic [15:0] M68K_DIN,
  output logic        nAS,
  output logic        nUDS,
  output logic        nLDS,
  output logic        M68K_RW,
  input  logic        nDTACK
);

  localparam logic [7:0] TO_C = 8'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, S0, S2, S4, S6, S7} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [22:0] addr_q, addr_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        timeout_d;

  // Registered output copies
  logic        busy_q, ack_q, err_q, dout_en_q, nas_q, nuds_q, nlds_q, rw_q;
  logic [15:0] rdata_q, dout_q;
  logic [7:0]  waits_q;
  logic [22:0] maddr_q;

  // Next-state and request latch
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: if (REQ) begin
        we_d    = REQ_WE;
        addr_d  = REQ_ADDR;
        be_d    = (REQ_BE == 2'b00) ? 2'b11 : REQ_BE;
        wdata_d = REQ_WDATA;
        state_d = S0;
      end
      S0: begin
        cnt_d   = 8'd0;
        state_d = S2;
      end
      S2: state_d = S4;
      S4: begin
        if (!nDTACK) begin
          state_d = S6;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TO_C) begin
            state_d   = S7;
            timeout_d = 1'b1;
          end
        end
      end
      S6: state_d = S7;
      S7: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state so that, once registered, they
  // line up with the state the block is actually in during that cycle.
  logic as_phase, ds_phase, drive_phase;
  always_comb begin
    as_phase    = state_d inside {S2, S4, S6};
    // Writes assert data strobes one cycle after nAS, once data is stable.
    ds_phase    = we_d ? (state_d inside {S4, S6}) : as_phase;
    drive_phase = state_d inside {S0, S2, S4, S6};
  end

  always_ff @(posedge CLK_68KCLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= 2'b11;
      wdata_q   <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dout_en_q <= 1'b0;
      nas_q     <= 1'b1;
      nuds_q    <= 1'b1;
      nlds_q    <= 1'b1;
      rw_q      <= 1'b1;
      rdata_q   <= '0;
      dout_q    <= '0;
      waits_q   <= '0;
      maddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      busy_q    <= (state_d != IDLE);
      ack_q     <= (state_d == S7);
      err_q     <= (state_d == S7) && timeout_d;
      nas_q     <= !as_phase;
      nuds_q    <= !(ds_phase && be_d[1]);
      nlds_q    <= !(ds_phase && be_d[0]);
      rw_q      <= !(we_d && drive_phase);
      dout_en_q <= we_d && as_phase;
      if (state_d == S7) waits_q <= cnt_d;
      if (state_d == S0) maddr_q <= addr_d;
      if (state_d == S2 && we_d) dout_q <= wdata_d;
      if (state_q == S6 && !we_q) rdata_q <= M68K_DIN;
    end
  end

  assign BUSY         = busy_q;
  assign ACK          = ack_q;
  assign ERR          = err_q;
  assign RDATA        = rdata_q;
  assign WAITS        = waits_q;
  assign M68K_ADDR    = maddr_q;
  assign M68K_DOUT    = dout_q;
  assign M68K_DOUT_EN = dout_en_q;
  assign nAS          = nas_q;
  assign nUDS         = nuds_q;
  assign nLDS         = nlds_q;
  assign M68K_RW      = rw_q;

endmodule

// File: tb/tb_m68k_bus_master.sv
// Bench for m68k_bus_master: directed cases plus randomized transactions,
// checked against a cycle-count model of a bus transaction.
module tb_m68k_bus_master;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        RESET, REQ, REQ_WE, nDTACK;
  logic [22:0] REQ_ADDR;
  logic [1:0]  REQ_BE;
  logic [15:0] REQ_WDATA, M68K_DIN;
  logic        BUSY, ACK, ERR, M68K_DOUT_EN, nAS, nUDS, nLDS, M68K_RW;
  logic [15:0] RDATA, M68K_DOUT;
  logic [7:0]  WAITS;
  logic [22:0] M68K_ADDR;

  int pass_cnt = 0;
  int total    = 0;
  logic [15:0] rdata_m = 16'h0000;

  m68k_bus_master #(.TIMEOUT(TMO)) dut (
    .CLK_68KCLK(clk), .RESET(RESET), .REQ(REQ), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_BE(REQ_BE), .REQ_WDATA(REQ_WDATA),
    .BUSY(BUSY), .ACK(ACK), .ERR(ERR), .RDATA(RDATA), .WAITS(WAITS),
    .M68K_ADDR(M68K_ADDR), .M68K_DOUT(M68K_DOUT), .M68K_DOUT_EN(M68K_DOUT_EN),
    .M68K_DIN(M68K_DIN), .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS),
    .M68K_RW(M68K_RW), .nDTACK(nDTACK)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Runs one request starting in an IDLE cycle (cycle 0). n = wait count;
  // n >= TMO means the responder never acknowledges. hold keeps REQ and
  // fields asserted after the sampling cycle.
  task automatic run_txn(input logic we, input logic [22:0] addr, input logic [1:0] be,
                         input logic [15:0] wdata, input logic [15:0] din,
                         input int n, input bit hold);
    bit          to;
    logic [1:0]  bee;
    int          exp_ack, exp_as, exp_ds, exp_rw, exp_en;
    int          ack_c, as_lo, uds_lo, lds_lo, rw_lo, en_cnt, dout_bad, busy_lo;
    logic [22:0] addr_c1;
    logic [4:0]  at_ack;
    logic        err_o;
    logic [7:0]  waits_o;
    logic [15:0] rdata_o;
    to  = (n >= TMO);
    bee = (be == 2'b00) ? 2'b11 : be;
    exp_ack = to ? 3 + TMO : 5 + n;
    exp_as  = to ? 1 + TMO : 3 + n;
    exp_ds  = we ? (to ? TMO : 2 + n) : exp_as;
    exp_rw  = we ? (to ? 2 + TMO : 4 + n) : 0;
    exp_en  = we ? exp_as : 0;
    ack_c = -1; as_lo = 0; uds_lo = 0; lds_lo = 0; rw_lo = 0; en_cnt = 0;
    dout_bad = 0; busy_lo = 0; addr_c1 = '0; at_ack = '0;
    err_o = 1'b0; waits_o = '0; rdata_o = '0;

    REQ = 1'b1; REQ_WE = we; REQ_ADDR = addr; REQ_BE = be; REQ_WDATA = wdata;
    M68K_DIN = din;
    nDTACK = (!to && n == 0) ? 1'b0 : 1'b1;
    check("busy_c0", {31'b0, BUSY}, 32'd0);

    for (int c = 1; c <= 30 && ack_c < 0; c++) begin
      step();
      if (!hold) begin
        REQ = 1'b0; REQ_WE = 1'($urandom); REQ_ADDR = 23'($urandom);
        REQ_BE = 2'($urandom); REQ_WDATA = 16'($urandom);
      end
      nDTACK = (!to && (n == 0 || c >= 3 + n)) ? 1'b0 : 1'b1;
      if (c == 1) addr_c1 = M68K_ADDR;
      if (!BUSY) busy_lo++;
      if (ACK) begin
        ack_c = c; err_o = ERR; waits_o = WAITS; rdata_o = RDATA;
        at_ack = {nAS, nUDS, nLDS, M68K_DOUT_EN, M68K_RW};
      end else begin
        if (!nAS) as_lo++;
        if (!nUDS) uds_lo++;
        if (!nLDS) lds_lo++;
        if (!M68K_RW) rw_lo++;
        if (M68K_DOUT_EN) begin
          en_cnt++;
          if (M68K_DOUT !== wdata) dout_bad++;
        end
      end
    end
    nDTACK = 1'b1;
    if (!to && !we) rdata_m = din;

    $display("txn we=%0d addr=%06h be=%0b n=%0d ack@%0d err=%0d waits=%0d rdata=%04h",
             we, addr, be, n, ack_c, err_o, waits_o, rdata_o);
    check("ack_cycle", 32'(ack_c), 32'(exp_ack));
    check("err",       {31'b0, err_o}, {31'b0, to});
    check("waits",     {24'b0, waits_o}, to ? 32'(TMO) : 32'(n));
    check("rdata",     {16'b0, rdata_o}, {16'b0, rdata_m});
    check("addr",      {9'b0, addr_c1}, {9'b0, addr});
    check("nas_lo",    32'(as_lo), 32'(exp_as));
    check("nuds_lo",   32'(uds_lo), bee[1] ? 32'(exp_ds) : 32'd0);
    check("nlds_lo",   32'(lds_lo), bee[0] ? 32'(exp_ds) : 32'd0);
    check("rw_lo",     32'(rw_lo), 32'(exp_rw));
    check("douten",    32'(en_cnt), 32'(exp_en));
    check("dout_val",  32'(dout_bad), 32'd0);
    check("busy_run",  32'(busy_lo), 32'd0);
    check("released",  {27'b0, at_ack}, 32'b11101);
    step();   // IDLE cycle: also cycle 0 of any following request
    check("busy_idle", {30'b0, BUSY, ACK}, 32'd0);
  endtask

  initial begin
    RESET = 1'b1; REQ = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_BE = '0;
    REQ_WDATA = '0; M68K_DIN = '0; nDTACK = 1'b1;
    step(); step();
    RESET = 1'b0;
    check("rst_strobes", {28'b0, nAS, nUDS, nLDS, M68K_RW}, 32'hF);
    check("rst_flags",   {28'b0, BUSY, ACK, ERR, M68K_DOUT_EN}, 32'h0);
    check("rst_data",    {RDATA, M68K_DOUT}, 32'h0);
    check("rst_addr",    {1'b0, M68K_ADDR, WAITS}, 32'h0);
    step();

    // Zero-wait read
    run_txn(1'b0, 23'h080000 >> 1, 2'b11, 16'h0000, 16'hA55A, 0, 1'b0);
    // Write with three waits, upper byte only
    run_txn(1'b1, 23'h012345, 2'b10, 16'h1234, 16'h0000, 3, 1'b0);
    // Timeout read: RDATA must keep 0xA55A
    run_txn(1'b0, 23'h300000, 2'b11, 16'h0000, 16'hDEAD, TMO, 1'b0);
    // Timeout write
    run_txn(1'b1, 23'h300001, 2'b01, 16'h5AA5, 16'h0000, TMO, 1'b0);
    // REQ held high: back-to-back zero-wait reads
    run_txn(1'b0, 23'h000100, 2'b11, 16'h0000, 16'h1111, 0, 1'b1);
    run_txn(1'b0, 23'h000102, 2'b11, 16'h0000, 16'h2222, 0, 1'b0);
    // Byte enables 00 treated as both bytes
    run_txn(1'b0, 23'h000200, 2'b00, 16'h0000, 16'h3C3C, 2, 1'b0);

    // Reset during S4
    REQ = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 23'h000300; REQ_BE = 2'b11; nDTACK = 1'b1;
    step(); REQ = 1'b0;
    step(); step(); step();      // cycle 4
    RESET = 1'b1;
    step();                      // cycle 5
    RESET = 1'b0;
    $display("reset-in-S4: nAS=%0b nUDS=%0b nLDS=%0b BUSY=%0b ACK=%0b", nAS, nUDS, nLDS, BUSY, ACK);
    check("rstS4_strobes", {29'b0, nAS, nUDS, nLDS}, 32'h7);
    check("rstS4_busy",    {30'b0, BUSY, ACK}, 32'h0);
    begin
      int acks = 0;
      for (int i = 0; i < 6; i++) begin step(); if (ACK) acks++; end
      check("rstS4_noack", 32'(acks), 32'd0);
    end
    run_txn(1'b0, 23'h000304, 2'b11, 16'h0000, 16'h4D4D, 1, 1'b0);

    // Randomized transactions
    for (int k = 0; k < 24; k++) begin
      run_txn(1'($urandom), 23'($urandom), 2'($urandom), 16'($urandom),
              16'($urandom), int'($urandom_range(0, TMO)), 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/m68k_bus_master.md
# m68k_bus_master

Synchronous 68000-style bus initiator. It turns single-word read/write requests from an internal client (loader, debug port, DMA) into nAS/nUDS/nLDS/R/W bus cycles on the NeoGeo 68k address map. It completes each cycle when the zone's wait-state logic asserts nDTACK. A programmable timeout terminates cycles that never receive nDTACK and flags them as bus errors.

## Interface

Parameters:
- TIMEOUT, 255: number of S4 cycles without nDTACK before the cycle aborts (1..255).

Ports:
- CLK_68KCLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ  in  1  client request; sampled only in IDLE.
- REQ_WE  in  1  1 = write, 0 = read; latched with REQ.
- REQ_ADDR  in  23  word address A[23:1]; latched with REQ.
- REQ_BE  in  2  byte enables {upper, lower}; latched with REQ; 2'b00 is treated as 2'b11.
- REQ_WDATA  in  16  write data; latched with REQ.
- BUSY  out  1  high in every state except IDLE.
- ACK  out  1  one-cycle completion pulse.
- ERR  out  1  valid with ACK; 1 = timeout abort.
- RDATA  out  16  read data; holds its value until the next successful read.
- WAITS  out  8  S4 cycles spent beyond the first in the last completed cycle; saturates at 255.
- M68K_ADDR  out  23  bus address.
- M68K_DOUT  out  16  bus write data.
- M68K_DOUT_EN  out  1  data bus drive enable.
- M68K_DIN  in  16  bus read data.
- nAS, nUDS, nLDS  out  1  active-low strobes.
- M68K_RW  out  1  1 = read, 0 = write.
- nDTACK  in  1  active-low acknowledge from the wait-state logic.

## Operation

All outputs are registered.

States and per-state behaviour:
- IDLE: nAS = nUDS = nLDS = 1, M68K_RW = 1, M68K_DOUT_EN = 0, BUSY = 0. If REQ = 1, latch the REQ_* inputs and go to S0.
- S0: drive M68K_ADDR and M68K_RW (0 for a write); strobes stay high. Go to S2.
- S2: nAS = 0. On a read, assert nUDS/nLDS per BE. On a write, set M68K_DOUT_EN = 1 and drive M68K_DOUT; strobes stay high. Go to S4.
- S4: on a write, assert nUDS/nLDS per BE. Sample nDTACK every cycle.
  - nDTACK = 0: go to S6.
  - nDTACK = 1: increment the wait counter. When the count reaches TIMEOUT, go to S7 with the error flag set.
- S6: on a read, latch M68K_DIN into RDATA. Go to S7.
- S7: nAS, nUDS and nLDS return to 1; M68K_DOUT_EN = 0; M68K_RW = 1. Assert ACK = 1 with ERR and WAITS. Go to IDLE.

Rules:
- The client holds REQ_* stable only for the cycle in which REQ is sampled. A REQ that stays high starts a new bus cycle on the first IDLE cycle after ACK.
- A timeout abort leaves RDATA unchanged and reports WAITS = min(TIMEOUT, 255).
- Reset values: state IDLE; nAS = nUDS = nLDS = 1; M68K_RW = 1; M68K_DOUT_EN = 0; ACK = ERR = BUSY = 0; RDATA = 0; WAITS = 0; M68K_ADDR = 0; M68K_DOUT = 0.
- RESET in any state returns the block to IDLE on the next edge with all strobes released. The interrupted cycle produces no ACK.

## Timing

Cycle numbering: REQ is sampled in IDLE at cycle 0.
- S0 at cycle 1 and S2 at cycle 2.
- First S4 at cycle 3. With nDTACK low at cycle 3 (zero waits): S6 at 4, S7/ACK at 5, IDLE at 6. The next REQ can be sampled at cycle 6.
- Each S4 cycle with nDTACK high adds one cycle. With N waits, ACK falls at cycle 5 + N and WAITS = N.
- Timeout: S7/ACK with ERR = 1 at cycle 3 + TIMEOUT.
- nAS is low from S2 through S6: 3 + N cycles.
- On a read, data strobes are low for the same span as nAS. On a write, they go low one cycle later.
- nDTACK is sampled only in S4. A level already low at S2 does not shorten the cycle below zero waits.

## Test plan

- Zero-wait read: nDTACK tied low, REQ_ADDR = 0x080000 >> 1, M68K_DIN = 0xA55A → ACK at cycle 5, RDATA = 0xA55A, WAITS = 0, ERR = 0, nAS low for 3 cycles.
- Write with 3 waits: the responder asserts nDTACK at the fourth S4 cycle, REQ_BE = 2'b10, REQ_WDATA = 0x1234 → nUDS low and nLDS high, M68K_DOUT = 0x1234 while DOUT_EN = 1, ACK at cycle 8, WAITS = 3.
- Timeout with TIMEOUT = 8: nDTACK held high → ACK with ERR = 1 at cycle 11, WAITS = 8, RDATA unchanged, strobes released in S7.
- REQ held high: two read requests in a row with zero waits → second cycle enters S0 at cycle 7, ACKs at cycles 5 and 11, BUSY low only at cycle 6.
- Reset during S4 (at cycle 4) → IDLE at cycle 5, all strobes high, no ACK; the next REQ runs normally.
- Byte enables 2'b00 on a read → both nUDS and nLDS asserted.
